// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers feed a per-channel 3x3 shift
// register; one registered window is emitted per accepted pixel at row>=2, col>=2.
module conv3x3_window_gen #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned IMG_W        = 8,
    parameter int unsigned IMG_H        = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              pix_valid,
    input  logic                                              pix_sof,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]           pix_in,
    output logic [NUM_CHANNELS-1:0][2:0][2:0][DATA_WIDTH-1:0] win_out,
    output logic                                              win_valid,
    output logic [$clog2(IMG_H)-1:0]                          win_row,
    output logic [$clog2(IMG_W)-1:0]                          win_col,
    output logic                                              frame_done,
    output logic                                              sof_err
);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);

    typedef logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]           pix_t;
    typedef logic [NUM_CHANNELS-1:0][2:0][2:0][DATA_WIDTH-1:0] win_t;
    typedef pix_t [IMG_W-1:0]                                  line_t;

    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    line_t            lb1_q, lb1_d;
    line_t            lb2_q, lb2_d;
    win_t             sr_q, sr_d;
    win_t             win_out_q, win_out_d;
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;
    logic             sof_err_q, sof_err_d;
    logic             sof_restart;

    // A misplaced sof forces the pixel to be treated as (0,0) of a new frame
    always_comb begin
        sof_restart  = pix_valid && pix_sof && ((row_q != '0) || (col_q != '0));
        cur_row      = sof_restart ? '0 : row_q;
        cur_col      = sof_restart ? '0 : col_q;

        row_d        = row_q;
        col_d        = col_q;
        lb1_d        = lb1_q;
        lb2_d        = lb2_q;
        sr_d         = sr_q;
        win_out_d    = win_out_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;

        if (pix_valid) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    sr_d[ch][i][0] = sr_q[ch][i][1];
                    sr_d[ch][i][1] = sr_q[ch][i][2];
                end
                sr_d[ch][0][2] = lb2_q[cur_col][ch];
                sr_d[ch][1][2] = lb1_q[cur_col][ch];
                sr_d[ch][2][2] = pix_in[ch];
            end
            lb2_d[cur_col] = lb1_q[cur_col];
            lb1_d[cur_col] = pix_in;

            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end

            if (!sof_restart && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2))) begin
                win_valid_d = 1'b1;
                win_out_d   = sr_d;
                win_row_d   = cur_row;
                win_col_d   = cur_col;
            end
            frame_done_d = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
            sof_err_d    = sof_restart;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            lb1_q        <= '0;
            lb2_q        <= '0;
            sr_q         <= '0;
            win_out_q    <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            lb1_q        <= lb1_d;
            lb2_q        <= lb2_d;
            sr_q         <= sr_d;
            win_out_q    <= win_out_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign win_out    = win_out_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen on a 4x4x3 frame: windows are predicted from an image array
// holding every pixel the bench has sent, indexed by its raster position.
module tb_conv3x3_window_gen;
    localparam int DW = 8;
    localparam int C  = 3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = C * DW;

    typedef logic [C-1:0][2:0][2:0][DW-1:0] win_t;
    typedef logic [C-1:0][DW-1:0]           pix_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic       pix_sof;
    pix_t       pix_in;
    win_t       win_out;
    logic       win_valid;
    logic [1:0] win_row;
    logic [1:0] win_col;
    logic       frame_done;
    logic       sof_err;

    conv3x3_window_gen #(
        .DATA_WIDTH  (DW),
        .NUM_CHANNELS(C),
        .IMG_W       (W),
        .IMG_H       (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_in    (pix_in),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    pix_t       img [H][W];
    win_t       last_win;
    logic [1:0] last_row;
    logic [1:0] last_col;
    int         n_cmp;
    int         n_err;
    int         obs_win;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t fpix(input int r, input int c, input int base);
        pix_t p;
        for (int k = 0; k < C; k++) p[k] = DW'(4 * r + c + 16 * k + base);
        return p;
    endfunction

    function automatic win_t model_win(input int r, input int c);
        win_t w;
        for (int k = 0; k < C; k++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[k][i][j] = img[r - 2 + i][c - 2 + j][k];
        return w;
    endfunction

    task automatic send_pix(input int r, input int c, input logic sof, input pix_t p,
                            input bit exp_err);
        bit exp_v;
        img[r][c] = p;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = p;
        @(posedge clk);
        #1;
        exp_v = (r >= 2) && (c >= 2);
        if (exp_v) begin
            last_win = model_win(r, c);
            last_row = 2'(r);
            last_col = 2'(c);
        end
        if (win_valid === 1'b1) obs_win++;
        chk("win_valid", 256'(win_valid), 256'(exp_v));
        chk("win_out", 256'(win_out), 256'(last_win));
        chk("win_row", 256'(win_row), 256'(last_row));
        chk("win_col", 256'(win_col), 256'(last_col));
        chk("frame_done", 256'(frame_done), 256'((r == H - 1) && (c == W - 1)));
        chk("sof_err", 256'(sof_err), 256'(exp_err));
    endtask

    task automatic send_idle();
        pix_valid = 1'b0;
        pix_sof   = 1'($urandom);
        pix_in    = PW'($urandom);
        @(posedge clk);
        #1;
        if (win_valid === 1'b1) obs_win++;
        chk("idle_win_valid", 256'(win_valid), 256'(0));
        chk("idle_win_out", 256'(win_out), 256'(last_win));
        chk("idle_win_row", 256'(win_row), 256'(last_row));
        chk("idle_win_col", 256'(win_col), 256'(last_col));
        chk("idle_frame_done", 256'(frame_done), 256'(0));
        chk("idle_sof_err", 256'(sof_err), 256'(0));
    endtask

    // gap_mode: 0 none, 1 idle after every pixel, 2 random idles
    task automatic send_range(input int base, input int gap_mode, input bit rnd, input bit err0,
                              input int from, input int to);
        for (int idx = from; idx <= to; idx++) begin
            int   r;
            int   c;
            pix_t p;
            r = idx / W;
            c = idx % W;
            p = rnd ? PW'($urandom) : fpix(r, c, base);
            send_pix(r, c, idx == 0, p, err0 && (idx == 0));
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) send_idle();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_win_out"}, 256'(win_out), 256'(0));
        chk({tag, "_win_valid"}, 256'(win_valid), 256'(0));
        chk({tag, "_win_row"}, 256'(win_row), 256'(0));
        chk({tag, "_win_col"}, 256'(win_col), 256'(0));
        chk({tag, "_frame_done"}, 256'(frame_done), 256'(0));
        chk({tag, "_sof_err"}, 256'(sof_err), 256'(0));
    endtask

    logic [2:0][2:0][DW-1:0] lit;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        obs_win   = 0;
        last_win  = '0;
        last_row  = '0;
        last_col  = '0;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Full frame, first and last window against hand-computed values
        obs_win = 0;
        send_range(0, 0, 0, 0, 0, 10);
        lit = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        chk("first_win_ch0", 256'(win_out[0]), 256'(lit));
        send_range(0, 0, 0, 0, 11, 15);
        lit = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
        chk("last_win_ch0", 256'(win_out[0]), 256'(lit));
        lit = {8'd47, 8'd46, 8'd45, 8'd43, 8'd42, 8'd41, 8'd39, 8'd38, 8'd37};
        chk("last_win_ch2", 256'(win_out[2]), 256'(lit));
        chk("frame1_pulses", 256'(obs_win), 256'(4));

        // pix_valid low every other cycle
        obs_win = 0;
        send_range(0, 1, 0, 0, 0, 15);
        chk("gapped_pulses", 256'(obs_win), 256'(4));

        // Two frames back-to-back, second offset by 100
        obs_win = 0;
        send_range(0, 0, 0, 0, 0, 15);
        send_range(100, 0, 0, 0, 0, 10);
        lit = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
        chk("frame2_first_ch0", 256'(win_out[0]), 256'(lit));
        send_range(100, 0, 0, 0, 11, 15);
        chk("b2b_pulses", 256'(obs_win), 256'(8));

        // sof injected at counter position (1,3)
        obs_win = 0;
        send_range(0, 0, 0, 0, 0, 6);
        send_range(0, 0, 0, 1, 0, 15);
        chk("sof_restart_pulses", 256'(obs_win), 256'(4));

        // Asynchronous reset mid-cycle while pixel (2,3) is presented
        send_range(0, 0, 0, 0, 0, 10);
        pix_valid = 1'b1;
        pix_sof   = 1'b0;
        pix_in    = fpix(2, 3, 0);
        #2 rst_n  = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        #2 rst_n  = 1'b1;
        @(posedge clk);
        #1;
        last_win = '0;
        last_row = '0;
        last_col = '0;
        check_all_zero("post_rst");
        obs_win = 0;
        send_range(0, 0, 0, 0, 0, 10);
        lit = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        chk("post_rst_first_ch0", 256'(win_out[0]), 256'(lit));
        send_range(0, 0, 0, 0, 11, 15);
        chk("post_rst_pulses", 256'(obs_win), 256'(4));

        // Random pixel data with random idle cycles, several frames
        obs_win = 0;
        for (int f = 0; f < 4; f++) send_range(0, 2, 1, 0, 0, 15);
        chk("random_pulses", 256'(obs_win), 256'(16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
